// File: rtl/regfile_2r1w_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_2r1w_if : write port and two read ports of the register file
// Revision: 1.0
// ---------------------------------------------------------------------------
interface regfile_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_2r1w : 2 combinational read ports, 1 synchronous write port
// Revision: 1.0
// ---------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0
) (
  input  wire              clk,
  input  wire              rst_n,
  regfile_2r1w_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  // Writes to entry 0 are dropped when it is hardwired, which also kills bypass there
  assign wr_en = bus.we && !(ZERO_REG && (bus.waddr == '0));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (bus.waddr == ADDR_W'(i))) begin
        mem_d[i] = bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    rdata1 = mem_q[bus.raddr1];
    if (BYPASS && wr_en && (bus.raddr1 == bus.waddr)) begin
      rdata1 = bus.wdata;
    end
    if (ZERO_REG && (bus.raddr1 == '0)) begin
      rdata1 = '0;
    end
  end

  always_comb begin
    rdata2 = mem_q[bus.raddr2];
    if (BYPASS && wr_en && (bus.raddr2 == bus.waddr)) begin
      rdata2 = bus.wdata;
    end
    if (ZERO_REG && (bus.raddr2 == '0)) begin
      rdata2 = '0;
    end
  end

  assign bus.rdata1 = rdata1;
  assign bus.rdata2 = rdata2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_2r1w : directed bench for regfile_2r1w (ZERO_REG=1, BYPASS=0)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_regfile_2r1w;

  typedef struct {
    string       tag;
    bit          port;
    logic [31:0] exp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] model [32];

  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_2r1w #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input bit port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = e.port ? bus.rdata2 : bus.rdata1;
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s port%0d observed=%h expected=%h", e.tag, e.port + 1, obs, e.exp);
      end
    end
  endtask

  // Set both read addresses, queue model values, compare after settling
  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    bus.raddr1 = a1;
    bus.raddr2 = a2;
    push_exp(tag, 1'b0, (a1 == 5'd0) ? 32'h0 : model[a1]);
    push_exp(tag, 1'b1, (a2 == 5'd0) ? 32'h0 : model[a2]);
    #1;
    drain();
  endtask

  // Drive a write at the negedge, commit on the next posedge
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(posedge clk);
    if (rst_n && a != 5'd0) model[a] = d;
  endtask

  initial begin
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      read_check("reset_zero", 5'(a), 5'(31 - a));
    end

    do_write(5'd10, 32'd10);
    do_write(5'd20, 32'd20);
    @(negedge clk);
    bus.we = 1'b0;
    read_check("seq_write", 5'd10, 5'd20);

    do_write(5'd0, 32'hDEADBEEF);
    @(negedge clk);
    bus.we = 1'b0;
    read_check("zero_reg", 5'd0, 5'd0);

    do_write(5'd7, 32'hA5A5A5A5);
    @(negedge clk);
    bus.we    = 1'b0;
    bus.waddr = 5'd7;
    bus.wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    read_check("we_low_hold", 5'd7, 5'd7);
    checks++;
    assert (bus.rdata1 === 32'hA5A5A5A5) else begin
      failures++;
      $error("FAIL we_low_const observed=%h expected=%h", bus.rdata1, 32'hA5A5A5A5);
    end

    do_write(5'd31, 32'hFFFFFFFF);
    @(negedge clk);
    bus.we = 1'b0;
    read_check("addr31_both", 5'd31, 5'd31);

    do_write(5'd5, 32'd3);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'd9;
    read_check("collide_before", 5'd5, 5'd10);
    checks++;
    assert (bus.rdata1 === 32'd3) else begin
      failures++;
      $error("FAIL collide_old observed=%h expected=%h", bus.rdata1, 32'd3);
    end
    @(posedge clk);
    model[5] = 32'd9;
    #1;
    read_check("collide_after", 5'd5, 5'd20);

    @(negedge clk);
    rst_n     = 1'b0;
    bus.we    = 1'b1;
    bus.waddr = 5'd5;
    bus.wdata = 32'h77;
    @(posedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    rst_n  = 1'b1;
    bus.we = 1'b0;
    read_check("reset_over_write", 5'd5, 5'd31);
    read_check("reset_clears", 5'd10, 5'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
